// File: rtl/l1_mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package   : l1_arb_pkg
// Purpose   : Shared types and helpers for the L1 memory bus arbiter
//             (FSM state encoding, owner index width, default line bus type).
// Revision  : 1.0  initial release
// ============================================================================
package l1_arb_pkg;

  // Arbiter FSM states, explicitly 2 bits wide
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  // Default line geometry (N-bit words, two words per line)
  localparam int unsigned L1_ARB_N   = 32;
  localparam int unsigned L1_ARB_WPL = 2;

  // One cache line as seen on the memory port in the default geometry
  typedef logic [L1_ARB_WPL-1:0][L1_ARB_N-1:0] line_bus_t;

  // Width of an index able to name any of nreq requesters (at least 1 bit)
  function automatic int unsigned owner_w(input int unsigned nreq);
    int unsigned w;
    w = 1;
    if (nreq > 1) w = $unsigned($clog2(nreq));
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/l1_mem_bus_arbiter_picker.sv
`default_nettype none
// ============================================================================
// Module    : rr_priority_picker
// Purpose   : Combinational round-robin picker. Returns a one-hot vector naming
//             the first asserted request at or after rr_ptr_i (wrapping).
// Revision  : 1.0  initial release
// ============================================================================
module rr_priority_picker
  import l1_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] rr_ptr_i,
  output logic [NREQ-1:0]  pick_o,
  output logic             any_req_o
);

  logic found;

  // Walk offsets 0..NREQ-1 from the pointer; the first requester hit wins
  always_comb begin
    pick_o = '0;
    found  = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && req_i[j] && (((int'(rr_ptr_i) + off) % NREQ) == j)) begin
          pick_o[j] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

  assign any_req_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/l1_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module    : l1_mem_bus_arbiter
// Purpose   : Round-robin arbiter sharing one main-memory port between NREQ
//             L1 caches. The owner's line address / write data are muxed onto
//             the memory port, mem_ready is routed back to the owner only and
//             the owner's writes are broadcast as snoop_addr/snoop_we.
// Options   : ARB_WATCHDOG_EN - builds a hold-time watchdog driving wd_err_o;
//             when undefined wd_err_o is tied low.
// Revision  : 1.0  initial release
// ============================================================================
module l1_mem_bus_arbiter
  import l1_arb_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int N            = 32,
  parameter int WORDSPERLINE = 2,
  parameter int WD_LIMIT     = 64
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NREQ-1:0]                        req_re_i,
  input  logic [NREQ-1:0]                        req_we_i,
  input  logic [NREQ-1:0][N-1:0]                 req_line_addr_i,
  input  logic [NREQ-1:0][N-1:0]                 req_byte_addr_i,
  input  logic [NREQ-1:0][WORDSPERLINE-1:0][N-1:0] req_data_i,
  output logic [NREQ-1:0]                        granted_o,
  output logic [NREQ-1:0]                        rsp_ready_o,
  output logic [WORDSPERLINE-1:0][N-1:0]         rsp_data_o,
  output logic                                   mem_re_o,
  output logic                                   mem_we_o,
  output logic [N-1:0]                           mem_addr_o,
  output logic [WORDSPERLINE-1:0][N-1:0]         mem_wdata_o,
  input  logic [WORDSPERLINE-1:0][N-1:0]         mem_rdata_i,
  input  logic                                   mem_ready_i,
  output logic [N-1:0]                           snoop_addr_o,
  output logic                                   snoop_we_o,
  output logic                                   wd_err_o
);

  localparam int OW = int'(owner_w(NREQ));

  arb_state_t        state_q, state_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]   granted_q, granted_d;

  logic [NREQ-1:0]   pick;
  logic              any_req;
  logic [OW-1:0]     pick_idx;
  logic              busy;

  rr_priority_picker #(
    .NREQ  (NREQ),
    .PTR_W (OW)
  ) u_picker (
    .req_i     (req_re_i),
    .rr_ptr_i  (rr_ptr_q),
    .pick_o    (pick),
    .any_req_o (any_req)
  );

  // Encode the picker's one-hot result into an owner index
  always_comb begin
    pick_idx = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (pick[j]) pick_idx = OW'(j);
    end
  end

  // FSM next state: arbitrate in IDLE, hold the bus until the owner drops req_re
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    granted_d = granted_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        granted_d          = '0;
        granted_d[owner_q] = 1'b1;
        state_d            = BUSY;
      end
      BUSY: begin
        if (!req_re_i[owner_q]) begin
          granted_d = '0;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        rr_ptr_d = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);
        state_d  = IDLE;
      end
      default: begin
        granted_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // State, owner, round-robin pointer and grant registers; async reset drops the grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      granted_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      granted_q <= granted_d;
    end
  end

  assign busy       = (state_q == BUSY);
  assign granted_o  = granted_q;
  assign rsp_data_o = mem_rdata_i;

  // Memory port and snoop mux: only the owner drives anything, and only in BUSY
  always_comb begin
    mem_re_o     = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    snoop_we_o   = 1'b0;
    snoop_addr_o = '0;
    rsp_ready_o  = '0;
    if (busy) begin
      mem_re_o             = req_re_i[owner_q];
      mem_we_o             = req_we_i[owner_q];
      mem_addr_o           = req_line_addr_i[owner_q];
      mem_wdata_o          = req_data_i[owner_q];
      snoop_we_o           = req_we_i[owner_q];
      snoop_addr_o         = req_byte_addr_i[owner_q];
      rsp_ready_o[owner_q] = mem_ready_i;
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_err_q, wd_err_d;
  logic            wd_hit;

  // Count BUSY cycles; the count restarts for every new grant and saturates at the limit
  always_comb begin
    wd_hit   = busy && (wd_cnt_q >= WD_W'(WD_LIMIT - 1));
    wd_cnt_d = wd_cnt_q;
    if (!busy) wd_cnt_d = '0;
    else if (!wd_hit) wd_cnt_d = wd_cnt_q + WD_W'(1);
    wd_err_d = wd_err_q | wd_hit;
  end

  // Watchdog counter and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_err_q <= wd_err_d;
    end
  end

  // The limit-reaching BUSY cycle already reports the error; the flag then holds it
  assign wd_err_o = wd_err_q | wd_hit;
`else
  logic unused_wd_limit;
  assign unused_wd_limit = (WD_LIMIT > 0);
  assign wd_err_o        = 1'b0;
`endif

endmodule
`default_nettype wire
